// File: rtl/pc_pkg.sv
// Shared definitions for the program counter and its return stack.
// Holds the command encoding and the command-priority decoder that the control FSM also uses.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_REL,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Priority is ret > call > load > inc. Lower-priority requests in the same cycle are dropped.
    function automatic pc_op_e pc_op_decode(
        input logic inc,
        input logic load,
        input logic rel,
        input logic call,
        input logic ret
    );
        if (ret)
            return PC_RET;
        else if (call)
            return PC_CALL;
        else if (load)
            return rel ? PC_REL : PC_LOAD;
        else if (inc)
            return PC_INC;
        else
            return PC_HOLD;
    endfunction

endpackage

// File: rtl/ret_stack_lifo.sv
// Return-address LIFO that holds DEPTH entries and tracks its own occupancy.
// The caller must gate push with !full and pop with !empty. The stack never checks this itself.
module ret_stack_lifo #(
    parameter int AW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [AW-1:0]              push_data,
    output logic [AW-1:0]              top,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty
);
    import pc_pkg::*;

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]  r_mem [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_rd_idx;

    assign w_wr_idx = IW'(r_sp);
    assign w_rd_idx = IW'(r_sp - SPW'(1));

    // NOTE: storage has no reset. Only sp defines which entries are valid, so the array can map to plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push)
            r_mem[w_wr_idx] <= push_data;
    end

    // NOTE: state registers use non-blocking assignment, so every reader in the same edge sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sp <= '0;
        else if (push)
            r_sp <= r_sp + SPW'(1);
        else if (pop)
            r_sp <= r_sp - SPW'(1);
    end

    assign top   = r_mem[w_rd_idx];
    assign sp    = r_sp;
    assign full  = (r_sp == SPW'(DEPTH));
    assign empty = (r_sp == '0);

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with increment, absolute/relative load and a hardware call/return stack.
// It has sticky overflow and underflow flags. All state is held while en is low.
module pc_stack_unit #(
    parameter int          AW      = 8,
    parameter int          DEPTH   = 4,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       inc,
    input  logic                       load,
    input  logic                       rel,
    input  logic                       call,
    input  logic                       ret,
    input  logic [AW-1:0]              target,
    input  logic                       err_clr,
    output logic [AW-1:0]              pc,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       err_ovf,
    output logic                       err_unf
);
    import pc_pkg::*;

    logic [AW-1:0] r_pc;
    logic          r_err_ovf;
    logic          r_err_unf;

    pc_op_e        w_op;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_top;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_evt;
    logic          w_unf_evt;

    assign w_op     = pc_op_decode(inc, load, rel, call, ret);
    assign w_pc_inc = r_pc + AW'(1);

    assign w_push    = en && (w_op == PC_CALL) && !w_full;
    assign w_pop     = en && (w_op == PC_RET)  && !w_empty;
    assign w_ovf_evt = en && (w_op == PC_CALL) &&  w_full;
    assign w_unf_evt = en && (w_op == PC_RET)  &&  w_empty;

    ret_stack_lifo #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (w_pc_inc),
        .top       (w_top),
        .sp        (sp),
        .full      (w_full),
        .empty     (w_empty)
    );

    // NOTE: the default assignment first means every path assigns w_pc_next, so no latch is inferred.
    always_comb begin
        w_pc_next = r_pc;
        unique case (w_op)
            PC_INC:  w_pc_next = w_pc_inc;
            PC_LOAD: w_pc_next = target;
            // Adding at width AW already gives the sign-extended offset result modulo 2^AW.
            PC_REL:  w_pc_next = r_pc + target;
            PC_CALL: w_pc_next = target;
            PC_RET:  w_pc_next = w_empty ? r_pc : w_top;
            default: w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pc <= RST_VEC;
        else if (en)
            r_pc <= w_pc_next;
    end

    // A clear and a new error in the same cycle leave the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else if (en) begin
            r_err_ovf <= w_ovf_evt || (r_err_ovf && !err_clr);
            r_err_unf <= w_unf_evt || (r_err_unf && !err_clr);
        end
    end

    assign pc      = r_pc;
    assign full    = w_full;
    assign empty   = w_empty;
    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;

endmodule
